// File: rtl/mux7_rr_arbiter.sv
// Round-robin arbiter sharing a 7-to-1 single-bit mux among seven requesters.
// Grant, MuxSelect and Valid are registered. There is no combinational path
// from Req to Grant. A holder that has kept the channel for MAX_HOLD cycles
// while someone else waits is moved aside. MAX_HOLD = 0 disables this.
// CW must satisfy 2**CW > MAX_HOLD so the hold counter can reach its limit.
//
// Handshake: Req[i] is a level request. Grant[i] is the matching registered
// acknowledge. Valid is high exactly when a grant is live. A requester owns
// the channel for every cycle its Grant bit is high. It releases the channel
// by dropping Req[i], and the arbiter reacts at the next rising edge.
module mux7_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Enable,
  input  logic [6:0] Req,
  output logic [6:0] Grant,
  output logic [2:0] MuxSelect,
  output logic       Valid,
  output logic       state_dbg
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Hold-counter value at which the current holder has completed MAX_HOLD cycles.
  localparam logic [CW-1:0] HOLD_LIM = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [CW-1:0] HOLD_SAT = '1;

  state_t        state;
  logic [2:0]    ptr;
  logic [CW-1:0] hold_cnt;

  logic [6:0] cand;
  logic       found;
  logic [2:0] win;
  logic [2:0] idx;
  logic       holder_req;
  logic       hold_expired;
  logic       take_new;
  logic       go_idle;

  // Candidates for the next grant: while busy the current holder is excluded.
  assign cand = (state == S_BUSY) ? (Req & ~Grant) : Req;

  // Rotating priority search starting just after the last-granted index.
  // Offset 7 wraps back to ptr itself, which matters only when idle.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    idx   = 3'd0;
    for (int k = 1; k <= 7; k++) begin
      idx = 3'((int'(ptr) + k) % 7);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign holder_req   = |(Req & Grant);
  assign hold_expired = (MAX_HOLD > 0) && (hold_cnt >= HOLD_LIM);

  // A new grant happens from idle, on holder release, or on hold expiry.
  // In every case Enable must be high and some candidate must be waiting.
  assign take_new = Enable && found &&
                    ((state == S_IDLE) || !holder_req || hold_expired);
  assign go_idle  = (state == S_BUSY) && !holder_req && !take_new;

  assign state_dbg = (state == S_BUSY);

  // Arbiter FSM: registered grant, select, valid, pointer and hold counter.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      Grant     <= 7'd0;
      MuxSelect <= 3'b111;
      Valid     <= 1'b0;
      hold_cnt  <= '0;
      ptr       <= 3'd6;
    end else if (take_new) begin
      state     <= S_BUSY;
      Grant     <= 7'b0000001 << win;
      MuxSelect <= win;
      Valid     <= 1'b1;
      hold_cnt  <= '0;
      ptr       <= win;
    end else if (go_idle) begin
      state     <= S_IDLE;
      Grant     <= 7'd0;
      MuxSelect <= 3'b111;
      Valid     <= 1'b0;
      hold_cnt  <= '0;
    end else if (state == S_BUSY) begin
      if (hold_cnt != HOLD_SAT) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux7_rr_arbiter.sv
// Directed bench for mux7_rr_arbiter with MAX_HOLD = 4.
// Drivers push the expected {Valid, MuxSelect, Grant} for the following edge.
// A monitor pops one entry after each rising edge and compares it, and it
// also checks the output invariants on every cycle.
module tb_mux7_rr_arbiter;

  logic       Clock;
  logic       Resetn;
  logic       Enable;
  logic [6:0] Req;
  logic [6:0] Grant;
  logic [2:0] MuxSelect;
  logic       Valid;
  logic       state_dbg;

  int checks;
  int errors;

  logic [10:0] exp_q[$];

  mux7_rr_arbiter #(.MAX_HOLD(4), .CW(4)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Enable    (Enable),
    .Req       (Req),
    .Grant     (Grant),
    .MuxSelect (MuxSelect),
    .Valid     (Valid),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Expected output word for a granted index, or for idle when idx == 7.
  function automatic logic [10:0] mk(input int idx);
    logic [6:0] g;
    if (idx == 7) return {1'b0, 3'b111, 7'd0};
    g = 7'b0000001 << idx;
    return {1'b1, 3'(idx), g};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got valid=%b sel=%b grant=%b, expected valid=%b sel=%b grant=%b",
               name, act[10], act[9:7], act[6:0], exp[10], exp[9:7], exp[6:0]);
    end
  endtask

  // Driver: apply one input vector for the next edge and queue its expected result.
  task automatic drive(input logic [6:0] r, input logic en, input int exp_idx);
    @(negedge Clock);
    Req    = r;
    Enable = en;
    exp_q.push_back(mk(exp_idx));
  endtask

  // Monitor / scoreboard
  initial begin
    logic [10:0] e;
    forever begin
      @(posedge Clock);
      #1;
      if (Resetn) begin
        checks++;
        if (!$onehot0(Grant) || (Valid !== (|Grant)) || (state_dbg !== Valid) ||
            ((Grant == 7'd0) ? (MuxSelect !== 3'b111)
                             : ((MuxSelect == 3'b111) || (Grant !== (7'b0000001 << MuxSelect))))) begin
          errors++;
          $display("FAIL invariant: got valid=%b sel=%b grant=%b dbg=%b, expected consistent one-hot outputs",
                   Valid, MuxSelect, Grant, state_dbg);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("scoreboard", {Valid, MuxSelect, Grant}, e);
        end
      end
    end
  end

  // Stimulus
  initial begin
    checks = 0;
    errors = 0;
    Resetn = 1'b0;
    Enable = 1'b1;
    Req    = 7'd0;

    // Reset held for two cycles
    repeat (2) @(posedge Clock);
    #1;
    check("reset_state", {Valid, MuxSelect, Grant}, mk(7));
    @(negedge Clock);
    Resetn = 1'b1;

    drive(7'd0, 1'b1, 7);
    drive(7'b1111111, 1'b1, 0);
    drive(7'd0, 1'b1, 7);

    // Single request on index 2, dropped at the fourth edge
    drive(7'b0000100, 1'b1, 2);
    drive(7'b0000100, 1'b1, 2);
    drive(7'b0000100, 1'b1, 2);
    drive(7'd0, 1'b1, 7);

    // Move the pointer to 6 so the fairness rotation starts at 0
    drive(7'b1000000, 1'b1, 6);
    drive(7'd0, 1'b1, 7);

    // Fairness: each holder drops for one cycle after its grant
    drive(7'b1111111, 1'b1, 0);
    for (int i = 0; i < 7; i++) begin
      drive(7'b1111111 & ~(7'b0000001 << i), 1'b1, (i + 1) % 7);
    end
    drive(7'd0, 1'b1, 7);

    // Preemption: requesters 3 and 5 hold for four cycles each in turn
    for (int i = 0; i < 4; i++) drive(7'b0101000, 1'b1, 3);
    for (int i = 0; i < 4; i++) drive(7'b0101000, 1'b1, 5);
    for (int i = 0; i < 2; i++) drive(7'b0101000, 1'b1, 3);
    drive(7'd0, 1'b1, 7);

    // Enable gating
    for (int i = 0; i < 3; i++) drive(7'b0010000, 1'b0, 7);
    drive(7'b0010000, 1'b1, 4);
    for (int i = 0; i < 20; i++) drive(7'b0010001, 1'b0, 4);
    drive(7'b0000001, 1'b0, 7);
    drive(7'b0000001, 1'b1, 0);
    drive(7'd0, 1'b1, 7);

    // Mid-grant asynchronous reset
    drive(7'b0000100, 1'b1, 2);
    @(posedge Clock);
    #3;
    Resetn = 1'b0;
    Req    = 7'b1000101;
    #1;
    check("async_reset", {Valid, MuxSelect, Grant}, mk(7));
    @(negedge Clock);
    Resetn = 1'b1;
    Enable = 1'b1;
    exp_q.push_back(mk(0));
    drive(7'd0, 1'b1, 7);

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
